// File: rtl/mprj_pkg.sv
// Shared types for the user-project BRAM arbiter.
// FSM encoding, bus widths and the captured beat.
package mprj_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam logic [31:0] BRAM_BASE = 32'h3800_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic              dma;
    logic              we;
    logic [SEL_W-1:0]  be;
    logic [DATA_W-1:0] wdata;
  } beat_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between Wishbone (a) and DMA (b).
// A held burst lock keeps b ahead on a tie.
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic prio_a,
  input  logic lock_b,
  output logic gnt_a,
  output logic gnt_b
);

  // b wins alone, under its burst lock, or on its turn
  always_comb begin
    gnt_b = req_b & (~req_a | lock_b | ~prio_a);
    gnt_a = req_a & ~gnt_b;
  end

endmodule

// File: rtl/mprjram_arbiter.sv
// Shares the single-port mprjram BRAM between Wishbone and DMA.
// One beat in flight, fixed read latency, bounded DMA bursts.
module mprjram_arbiter
  import mprj_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BRAM_BASE,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [SEL_W-1:0]  wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [SEL_W-1:0]  dma_wstrb,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              bram_en,
  output logic [SEL_W-1:0]  bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int LW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [LW-1:0] LAT_INIT =
    LW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

  state_t state;
  state_t state_nxt;
  beat_t  cur;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [LW-1:0]     lat_cnt;
  logic [BW-1:0]     burst_cnt;
  logic              rr_wb_first;
  logic              abort_q;
  logic              wb_req;
  logic              gnt_wb;
  logic              gnt_dma;
  logic              take;
  logic              unused_adr;

  // Only our 16 MiB window is claimed; other slaves own the rest
  assign wb_req = wbs_cyc_i & wbs_stb_i &
    (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  rr_arb2 u_arb (
    .req_a  (wb_req),
    .req_b  (dma_req),
    .prio_a (rr_wb_first),
    .lock_b (burst_cnt != '0),
    .gnt_a  (gnt_wb),
    .gnt_b  (gnt_dma)
  );

  assign take = (state == ST_IDLE) & (gnt_wb | gnt_dma);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: writes skip the latency wait
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (gnt_wb | gnt_dma) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (cur.we || RD_LAT == 1) state_nxt = ST_RESP;
        else                       state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winning side's beat at the grant edge
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cur    <= '0;
      addr_q <= '0;
    end else if (take) begin
      cur.dma <= gnt_dma;
      if (gnt_dma) begin
        cur.we    <= dma_we;
        cur.be    <= dma_we ? dma_wstrb : '0;
        cur.wdata <= dma_wdata;
        addr_q    <= dma_addr;
      end else begin
        cur.we    <= wbs_we_i;
        cur.be    <= wbs_we_i ? wbs_sel_i : '0;
        cur.wdata <= wbs_dat_i;
        addr_q    <= wbs_adr_i[ADDR_W+1:2];
      end
    end
  end

  // Read latency countdown across WAIT
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      lat_cnt <= '0;
    else if (state == ST_ISSUE)
      lat_cnt <= LAT_INIT;
    else if (state == ST_WAIT && lat_cnt != '0)
      lat_cnt <= lat_cnt - 1'b1;
  end

  // Round-robin turn and DMA burst length tracking
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rr_wb_first <= 1'b1;
      burst_cnt   <= '0;
    end else if (take) begin
      rr_wb_first <= gnt_dma;
      if (gnt_dma) begin
        if (dma_last || burst_cnt == BURST_END)
          burst_cnt <= '0;
        else
          burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // Read data capture and abandoned-cycle tracking
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      if (state_nxt == ST_RESP && !cur.we &&
          state != ST_RESP)
        rdata_q <= bram_rdata;
      if (take)
        abort_q <= 1'b0;
      else if (state != ST_IDLE && !cur.dma && !wbs_cyc_i)
        abort_q <= 1'b1;
    end
  end

  // Outputs decoded from state and the captured beat
  always_comb begin
    bram_en    = (state == ST_ISSUE);
    bram_we    = bram_en ? cur.be : '0;
    dma_gnt    = bram_en & cur.dma;
    wbs_ack_o  = (state == ST_RESP) & ~cur.dma &
                 ~abort_q & wbs_cyc_i;
    dma_rvalid = (state == ST_RESP) & cur.dma & ~cur.we;
    wbs_dat_o  = (wbs_ack_o & ~cur.we) ? rdata_q : '0;
    dma_rdata  = dma_rvalid ? rdata_q : '0;
  end

  assign bram_addr  = addr_q;
  assign bram_wdata = cur.wdata;

endmodule

// File: tb/tb_mprjram_arbiter.sv
// Scoreboard bench for mprjram_arbiter with a latency-exact BRAM model.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_mprjram_arbiter;

  localparam int AW = 10;
  localparam int RL = 10;
  localparam int K_EN = 1;
  localparam int K_GNT = 2;
  localparam int K_ACK = 3;
  localparam int K_RV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [3:0]    wbs_sel_i = 0;
  logic [31:0]   wbs_adr_i = 0, wbs_dat_i = 0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          dma_req = 0, dma_we = 0, dma_last = 0;
  logic [AW-1:0] dma_addr = 0;
  logic [31:0]   dma_wdata = 0;
  logic [3:0]    dma_wstrb = 0;
  logic          dma_gnt, dma_rvalid, bram_en;
  logic [31:0]   dma_rdata, bram_wdata, bram_rdata;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;

  mprjram_arbiter #(
    .BASE_ADDR(32'h3800_0000), .ADDR_W(AW),
    .RD_LAT(RL), .MAX_BURST(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wstrb(dma_wstrb), .dma_last(dma_last),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc_n++;

  // BRAM model: data valid only in cycle T+RL-1
  logic [31:0] mem [0:1023];
  logic [31:0] pd [0:RL-1];
  logic        pv [0:RL-1];

  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
    pd[0] <= mem[bram_addr];
    pv[0] <= bram_en && (bram_we == 4'b0);
    if (bram_en)
      for (int b = 0; b < 4; b++)
        if (bram_we[b])
          mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
  end

  assign bram_rdata = pv[RL-2] ? pd[RL-2] : 32'hFFFF_FFFF;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          cd;
  } exp_t;

  exp_t q[$];

  function automatic void ex(int kind, int c,
      logic [31:0] d0 = 0, logic [31:0] d1 = 0, bit cd = 1);
    exp_t e;
    e.kind = kind; e.cyc = c; e.d0 = d0; e.d1 = d1; e.cd = cd;
    q.push_back(e);
  endfunction

  function automatic logic [31:0] en_d(logic [3:0] be, int a);
    return {be, 18'b0, a[9:0]};
  endfunction

  task automatic see(int kind, logic [31:0] d0, logic [31:0] d1);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d got d0=%h d1=%h",
               kind, cyc_n, d0, d1);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc_n ||
          (e.cd && e.d0 != d0) ||
          (kind == K_EN && e.d0[31:28] != 4'b0 && e.d1 != d1)) begin
        n_bad++;
        $display("FAIL event got kind=%0d cyc=%0d d0=%h d1=%h exp kind=%0d cyc=%0d d0=%h d1=%h",
                 kind, cyc_n, d0, d1, e.kind, e.cyc, e.d0, e.d1);
      end
    end
  endtask

  // Monitor: every output pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_en)    see(K_EN, {bram_we, 18'b0, bram_addr}, bram_wdata);
      if (dma_gnt)    see(K_GNT, 32'h0, 32'h0);
      if (wbs_ack_o)  see(K_ACK, wbs_dat_o, 32'h0);
      if (dma_rvalid) see(K_RV, dma_rdata, 32'h0);
    end
  end

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {wbs_ack_o, wbs_dat_o, dma_gnt, dma_rvalid, dma_rdata,
            bram_en, bram_we, bram_addr, bram_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(int n);
    repeat (n) tick();
  endtask

  task automatic wb_go(bit we, logic [31:0] a, logic [3:0] s,
                       logic [31:0] d);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_adr_i = a; wbs_sel_i = s; wbs_dat_i = d;
  endtask

  task automatic wb_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack_o && n < 100);
    if (!wbs_ack_o) begin
      n_cmp++; n_bad++;
      $display("FAIL wb_ack_timeout got=none exp=ack");
    end
    @(posedge clk);
    #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic dma_beat(bit we, logic [AW-1:0] a, logic [31:0] d,
                          bit last, bit drop);
    int n = 0;
    dma_req = 1; dma_we = we; dma_addr = a;
    dma_wdata = d; dma_wstrb = 4'hF; dma_last = last;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_gnt && n < 100);
    if (!dma_gnt) begin
      n_cmp++; n_bad++;
      $display("FAIL dma_gnt_timeout got=none exp=gnt");
    end
    @(posedge clk);
    #1;
    if (drop) dma_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n_ev;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < RL; i++) begin pd[i] = 0; pv[i] = 0; end
    mem[2] = 32'h1111_1111;
    mem[4] = 32'h0000_021B;

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 128'h0);
    tick();
    rst = 0;
    quiet(2);
    chk("idle_outputs", outs(), 128'h0);

    // tie straight after reset: WB first
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'hF, 3), 32'hA5A5_0003);
    ex(K_ACK, k + 2, 0, 0, 0);
    ex(K_EN, k + 4, en_d(4'hF, 5), 32'h5555_0005);
    ex(K_GNT, k + 4);
    fork
      begin wb_go(1, 32'h3800_000C, 4'hF, 32'hA5A5_0003); wb_done(); end
      dma_beat(1, 10'd5, 32'h5555_0005, 1, 1);
    join
    quiet(10);

    // second tie: WB again, then DMA read-back
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'h0, 3));
    ex(K_ACK, k + 11, 32'hA5A5_0003);
    ex(K_EN, k + 13, en_d(4'h0, 5));
    ex(K_GNT, k + 13);
    ex(K_RV, k + 23, 32'h5555_0005);
    fork
      begin wb_go(0, 32'h3800_000C, 4'hF, 0); wb_done(); end
      dma_beat(0, 10'd5, 0, 1, 1);
    join
    quiet(15);

    // WB read of word 4
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'h0, 4));
    ex(K_ACK, k + 11, 32'h0000_021B);
    wb_go(0, 32'h3800_0010, 4'hF, 0);
    wb_done();
    quiet(3);

    // WB partial write of word 2
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'b0011, 2), 32'hDEAD_BEEF);
    ex(K_ACK, k + 2, 0, 0, 0);
    wb_go(1, 32'h3800_0008, 4'b0011, 32'hDEAD_BEEF);
    wb_done();
    quiet(3);

    // 6-beat DMA burst against a held WB read
    tick(); k = cyc_n;
    for (int i = 0; i < 4; i++) begin
      ex(K_EN, k + 1 + 3 * i, en_d(4'hF, 16 + i), 32'hB000_0001 + i);
      ex(K_GNT, k + 1 + 3 * i);
    end
    ex(K_EN, k + 13, en_d(4'h0, 4));
    ex(K_ACK, k + 23, 32'h0000_021B);
    for (int i = 4; i < 6; i++) begin
      ex(K_EN, k + 25 + 3 * (i - 4), en_d(4'hF, 16 + i),
         32'hB000_0001 + i);
      ex(K_GNT, k + 25 + 3 * (i - 4));
    end
    fork
      begin wb_go(0, 32'h3800_0010, 4'hF, 0); wb_done(); end
      for (int i = 0; i < 6; i++)
        dma_beat(1, AW'(16 + i), 32'hB000_0001 + i, i == 5, i == 5);
    join
    quiet(5);

    // WB drops cyc at T+3; DMA read of word 2 follows
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'h0, 4));
    ex(K_EN, k + 13, en_d(4'h0, 2));
    ex(K_GNT, k + 13);
    ex(K_RV, k + 23, 32'h1111_BEEF);
    wb_go(0, 32'h3800_0010, 4'hF, 0);
    quiet(4);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    tick();
    dma_beat(0, 10'd2, 0, 1, 1);
    quiet(20);

    // reset at T+5 of a DMA read
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'h0, 4));
    ex(K_GNT, k + 1);
    dma_beat(0, 10'd4, 0, 1, 1);
    quiet(4);
    rst = 1;
    @(negedge clk);
    chk("midop_reset_outputs", outs(), 128'h0);
    tick(); tick();
    rst = 0;
    quiet(20);

    // WB read after reset
    tick(); k = cyc_n;
    ex(K_EN, k + 1, en_d(4'h0, 4));
    ex(K_ACK, k + 11, 32'h0000_021B);
    wb_go(0, 32'h3800_0010, 4'hF, 0);
    wb_done();
    quiet(3);

    // foreign address never served
    tick();
    wb_go(0, 32'h3000_0000, 4'hF, 0);
    n_ev = 0;
    repeat (50) begin
      @(negedge clk);
      if (wbs_ack_o || bram_en) n_ev++;
    end
    chk("foreign_addr_events", 128'(n_ev), 128'h0);
    tick();
    wbs_cyc_i = 0; wbs_stb_i = 0;
    quiet(3);

    chk("expectations_left", 128'(q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
